// File: rtl/pe_pkg.sv
// Shared types and constants for the PE operand-assembly path.
// Covers the row-index encoding, the ifmap/filter select encoding and the loader FSM states.
package pe_pkg;

  localparam int ROWS = 3;
  localparam int ROW_IDX_W = 2;
  localparam int DEFAULT_FILTER_WIDTH = 8;

  localparam logic SEL_IFMAP  = 1'b0;
  localparam logic SEL_FILTER = 1'b1;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

  // A row index outside 0..ROWS-1 yields an all-zero mask.
  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_IDX_W-1:0] r);
    logic [ROWS-1:0] oh;
    for (int i = 0; i < ROWS; i++) begin
      oh[i] = (r == ROW_IDX_W'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/pe_window_loader_if.sv
// Bundles the depacketizer-side field handshake and the MAC-side window handshake.
// The slave modport is the loader; the master modport is its upstream and downstream environment.
interface pe_window_loader_if
  import pe_pkg::*;
#(
  parameter int FILTER_WIDTH = DEFAULT_FILTER_WIDTH
);
  localparam int ROW_W = ROWS * FILTER_WIDTH;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_timestep;
  logic                 in_ifmapb_filter;
  logic [ROW_IDX_W-1:0] in_filter_row;
  logic [ROW_W-1:0]     in_data;

  logic                 win_valid;
  logic                 win_ready;
  logic [ROWS*ROW_W-1:0] win_filter;
  logic [ROWS*ROW_W-1:0] win_ifmap;
  logic                 win_timestep;

  logic                 row_err;
  logic                 ts_err;

  modport master (
    output in_valid, in_timestep, in_ifmapb_filter, in_filter_row, in_data, win_ready,
    input  in_ready, win_valid, win_filter, win_ifmap, win_timestep, row_err, ts_err
  );

  modport slave (
    input  in_valid, in_timestep, in_ifmapb_filter, in_filter_row, in_data, win_ready,
    output in_ready, win_valid, win_filter, win_ifmap, win_timestep, row_err, ts_err
  );

endinterface

// File: rtl/pe_row_bank.sv
// ROWS-deep row register file with a per-row valid mask.
// Asserting clr together with we restarts the mask at the row being written.
module pe_row_bank
  import pe_pkg::*;
#(
  parameter int ROW_W = 3 * DEFAULT_FILTER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  clr,
  input  logic [ROW_IDX_W-1:0]  row,
  input  logic [ROW_W-1:0]      wdata,
  output logic [ROWS*ROW_W-1:0] rdata,
  output logic [ROWS-1:0]       mask
);

  logic [ROWS-1:0] mask_reg;

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      logic [ROW_W-1:0] row_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          row_reg <= '0;
        end else if (we && (row == ROW_IDX_W'(gi))) begin
          row_reg <= wdata;
        end
      end

      assign rdata[gi*ROW_W +: ROW_W] = row_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg <= '0;
    end else if (we && clr) begin
      mask_reg <= row_onehot(row);
    end else if (clr) begin
      mask_reg <= '0;
    end else if (we) begin
      mask_reg <= mask_reg | row_onehot(row);
    end
  end

  assign mask = mask_reg;

endmodule

// File: rtl/pe_window_loader.sv
// Assembles filter and ifmap rows into a 3x3 window for the MAC stage.
// Filters persist across windows; ifmap rows of one timestep are gathered and then cleared once the window is consumed.
module pe_window_loader
  import pe_pkg::*;
#(
  parameter int FILTER_WIDTH = DEFAULT_FILTER_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_window_loader_if.slave    bus
);

  localparam int ROW_W = ROWS * FILTER_WIDTH;
  localparam logic [ROWS-1:0] ALL_ROWS = '1;

  loader_state_t state_reg, state_next;

  logic ready_en_reg;
  logic cur_ts_reg;
  logic row_err_reg;
  logic ts_err_reg;

  logic [ROWS-1:0] filt_mask, ifm_mask, row_oh;
  logic [ROWS-1:0] filt_mask_next, ifm_mask_next;
  logic accept, row_ok, filt_we, ifm_we, ts_change, ifm_clr;
  logic in_ready_int, win_valid_int;

  assign row_oh    = row_onehot(bus.in_filter_row);
  assign accept    = bus.in_valid && in_ready_int;
  assign row_ok    = (row_oh != '0);
  assign filt_we   = accept && row_ok && (bus.in_ifmapb_filter == SEL_FILTER);
  assign ifm_we    = accept && row_ok && (bus.in_ifmapb_filter == SEL_IFMAP);
  assign ts_change = ifm_we && (ifm_mask != '0) && (bus.in_timestep != cur_ts_reg);
  assign ifm_clr   = ts_change || (win_valid_int && bus.win_ready);

  // Masks as they will be after this edge, so the window opens on the accepting edge.
  assign filt_mask_next = filt_mask | (filt_we ? row_oh : '0);
  assign ifm_mask_next  = ts_change ? row_oh : (ifm_mask | (ifm_we ? row_oh : '0));

  pe_row_bank #(.ROW_W(ROW_W)) u_filter_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (filt_we),
    .clr   (1'b0),
    .row   (bus.in_filter_row),
    .wdata (bus.in_data),
    .rdata (bus.win_filter),
    .mask  (filt_mask)
  );

  pe_row_bank #(.ROW_W(ROW_W)) u_ifmap_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (ifm_we),
    .clr   (ifm_clr),
    .row   (bus.in_filter_row),
    .wdata (bus.in_data),
    .rdata (bus.win_ifmap),
    .mask  (ifm_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD: if (filt_mask_next == ALL_ROWS && ifm_mask_next == ALL_ROWS) state_next = HOLD;
      HOLD: if (bus.win_ready) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // in_ready stays low while reset is held and rises at the first edge afterwards.
  always_comb begin
    in_ready_int  = 1'b0;
    win_valid_int = 1'b0;
    case (state_reg)
      LOAD: in_ready_int = ready_en_reg;
      HOLD: win_valid_int = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_reg <= 1'b0;
      cur_ts_reg   <= 1'b0;
      row_err_reg  <= 1'b0;
      ts_err_reg   <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      row_err_reg  <= accept && !row_ok;
      ts_err_reg   <= ts_change;
      if (ifm_we && (ifm_mask == '0 || ts_change)) begin
        cur_ts_reg <= bus.in_timestep;
      end
    end
  end

  assign bus.in_ready     = in_ready_int;
  assign bus.win_valid    = win_valid_int;
  assign bus.win_timestep = cur_ts_reg;
  assign bus.row_err      = row_err_reg;
  assign bus.ts_err       = ts_err_reg;

endmodule

// File: doc/pe_window_loader.md
# pe_window_loader

Clocked operand-assembly stage directly downstream of the PE depacketizer. Accepts depacketized fields (timestep, ifmap/filter select, row index, 3-element row data) over a valid/ready handshake and stores filter rows and ifmap rows in separate 3-row banks. When the filter bank is complete and all three ifmap rows of one timestep are present, it presents a full 3x3 window to the PE MAC stage and holds it until consumed. Filter rows persist across windows; ifmap rows are cleared after each window.

## Interface
- FILTER_WIDTH, 8, bits per element; each row carries 3 elements
- ROWS, 3, rows per window (fixed; sizes banks and masks)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream fields valid
- in_ready  output  1  loader can accept
- in_timestep  input  1  timestep tag (meaningful for ifmap rows only)
- in_ifmapb_filter  input  1  0 = ifmap row, 1 = filter row
- in_filter_row  input  2  row index 0..2; 3 is illegal
- in_data  input  3*FILTER_WIDTH  row data, element 0 in LSBs
- win_valid  output  1  window valid
- win_ready  input  1  MAC stage accepts window
- win_filter  output  9*FILTER_WIDTH  filter rows 0..2, row 0 in LSBs
- win_ifmap  output  9*FILTER_WIDTH  ifmap rows 0..2, row 0 in LSBs
- win_timestep  output  1  timestep of the window
- row_err  output  1  one-cycle pulse: illegal row index dropped
- ts_err  output  1  one-cycle pulse: partial ifmap set discarded on timestep change

## Operation
- States: LOAD, HOLD. Reset -> LOAD.
- Reset values: banks 0, filt_mask 3'b000, ifm_mask 3'b000, cur_ts 0, win_valid 0, row_err 0, ts_err 0; in_ready is 1 once reset deasserts (in LOAD).
- in_ready = (state == LOAD). Accept = in_valid && in_ready at a rising edge.
- Accept with row 3: nothing written, masks unchanged, row_err = 1 next cycle.
- Accept filter row r: filter_bank[r] <= in_data, filt_mask[r] <= 1. Rewriting a loaded row overwrites it; the mask stays set.
- Accept ifmap row r:
  - If ifm_mask == 0: cur_ts <= in_timestep.
  - If ifm_mask != 0 and in_timestep != cur_ts: ifm_mask <= one-hot(r), cur_ts <= in_timestep, ts_err = 1 next cycle. Old rows are discarded.
  - Otherwise ifmap_bank[r] <= in_data, ifm_mask[r] <= 1. Duplicate rows overwrite.
- LOAD -> HOLD on the edge where the updated filt_mask == 3'b111 and the updated ifm_mask == 3'b111.
- In HOLD: win_valid = 1, and win_* outputs are taken directly from the banks and cur_ts. They stay stable while win_valid && !win_ready.
- HOLD -> LOAD on win_valid && win_ready: ifm_mask <= 0; filt_mask and filter_bank are kept.
- No input is accepted in HOLD, so a filter update can never change a window that has been presented.

## Timing
- Accept-to-win_valid latency: 1 cycle. The edge that accepts the last missing row sets state = HOLD, and win_valid is high from that cycle on.
- Window handshake: the consumption edge drops win_valid. in_ready returns high in the following cycle, so there is 1 bubble cycle and no same-cycle window/input overlap.
- Minimum window period after filters are loaded: 3 ifmap accepts + 1 HOLD cycle = 4 cycles.
- Async reset mid-operation (any state) immediately restores all reset values and drops win_valid and in_ready. in_ready rises at the first edge after deassertion.
- in_valid without in_ready: the upstream holds the fields stable. The loader samples nothing.
- Error pulses are registered and last exactly 1 cycle. They are independent of state.

## Structure
- Shared package pe_pkg:
  - ROWS = 3
  - loader_state_t enum {LOAD, HOLD}
  - localparams for the field widths: row index width 2, select encoding IFMAP = 0, FILTER = 1
- Sub-module pe_row_bank:
  - ROWS x (3*FILTER_WIDTH) register file with a write-enable, a row index and a valid mask
  - Clear-mask input and a flat read-out
  - Instantiated twice: filter bank, ifmap bank
- The top level contains the FSM, timestep tracking and error pulses.

## Test plan
- Reset then load filter rows 0,1,2 = 24'h030201, 24'h060504, 24'h090807, then ifmap rows 0..2 = 24'h000101, 24'h010001, 24'h010100 with ts = 1:
  - win_valid rises 1 cycle after the 6th accept
  - win_filter = 72'h090807_060504_030201, win_ifmap = 72'h010100_010001_000101, win_timestep = 1
- Hold win_ready low for 5 cycles:
  - win_* stays stable and in_ready stays 0
  - on win_ready = 1, win_valid drops and in_ready returns the next cycle
- Second window with ifmap only (ts = 0): completes without reloading filters, and win_filter is unchanged.
- Ifmap rows 0,1 with ts = 0, then row 2 with ts = 1:
  - ts_err pulses once and ifm_mask = 3'b100
  - no window until rows 0,1 arrive with ts = 1
- Filter row index 3 with data 24'hFFFFFF: row_err pulses once and the banks and masks are unchanged.
- Assert rst while in HOLD:
  - win_valid drops immediately and the masks clear
  - after release, a full 6-row load is required for the next window
